// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester (fetch/data) and memory-side signals shared by the port arbiter.
// The arbiter takes the slave view; the pipeline/memory environment takes the master view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              i_If_Req;
  logic [ADDR_W-1:0] i_If_Addr;
  logic              o_If_Ready;
  logic [DATA_W-1:0] o_If_Data;

  logic              i_D_Req;
  logic              i_D_Wr;
  logic [ADDR_W-1:0] i_D_Addr;
  logic [DATA_W-1:0] i_D_WData;
  logic              o_D_Ready;
  logic [DATA_W-1:0] o_D_RData;

  logic              o_Err;
  logic              o_Stall;

  logic              o_Mem_Req;
  logic              o_Mem_Wr;
  logic [ADDR_W-1:0] o_Mem_Addr;
  logic [DATA_W-1:0] o_Mem_WData;
  logic              i_Mem_Ready;
  logic [DATA_W-1:0] i_Mem_RData;

  modport slave (
    input  i_If_Req, i_If_Addr, i_D_Req, i_D_Wr, i_D_Addr, i_D_WData,
           i_Mem_Ready, i_Mem_RData,
    output o_If_Ready, o_If_Data, o_D_Ready, o_D_RData, o_Err, o_Stall,
           o_Mem_Req, o_Mem_Wr, o_Mem_Addr, o_Mem_WData
  );

  modport master (
    output i_If_Req, i_If_Addr, i_D_Req, i_D_Wr, i_D_Addr, i_D_WData,
           i_Mem_Ready, i_Mem_RData,
    input  o_If_Ready, o_If_Data, o_D_Ready, o_D_RData, o_Err, o_Stall,
           o_Mem_Req, o_Mem_Wr, o_Mem_Addr, o_Mem_WData
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the IF and MEM stages, alternating on contention,
// stalling the pipeline while an access is outstanding and aborting unacknowledged accesses.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input logic               i_Clk,
  input logic               i_Rst,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, D_ACC, I_ACC, RESP} state_t;

  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

  state_t            state_q;
  logic              lastGrantData_q;
  logic [7:0]        timer_q;
  logic              memReq_q;
  logic              memWr_q;
  logic [ADDR_W-1:0] memAddr_q;
  logic [DATA_W-1:0] memWData_q;
  logic              ifReady_q;
  logic [DATA_W-1:0] ifData_q;
  logic              dReady_q;
  logic [DATA_W-1:0] dRData_q;
  logic              err_q;
  logic              grantData_d;

  // Data wins a tie unless it also won the previous grant, so neither side starves.
  assign grantData_d = bus.i_D_Req & (~bus.i_If_Req | ~lastGrantData_q);

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q         <= IDLE;
      lastGrantData_q <= 1'b0;
      timer_q         <= '0;
      memReq_q        <= 1'b0;
      memWr_q         <= 1'b0;
      memAddr_q       <= '0;
      memWData_q      <= '0;
      ifReady_q       <= 1'b0;
      ifData_q        <= '0;
      dReady_q        <= 1'b0;
      dRData_q        <= '0;
      err_q           <= 1'b0;
    end else begin
      ifReady_q <= 1'b0;
      dReady_q  <= 1'b0;
      err_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grantData_d) begin
            state_q         <= D_ACC;
            lastGrantData_q <= 1'b1;
            timer_q         <= '0;
            memReq_q        <= 1'b1;
            memWr_q         <= bus.i_D_Wr;
            memAddr_q       <= bus.i_D_Addr;
            memWData_q      <= bus.i_D_WData;
          end else if (bus.i_If_Req) begin
            state_q         <= I_ACC;
            lastGrantData_q <= 1'b0;
            timer_q         <= '0;
            memReq_q        <= 1'b1;
            memWr_q         <= 1'b0;
            memAddr_q       <= bus.i_If_Addr;
            memWData_q      <= '0;
          end
        end
        D_ACC, I_ACC: begin
          // Ready is honoured even on the last permitted cycle; abort only if still low then.
          if (bus.i_Mem_Ready || (timer_q == TIMER_LAST)) begin
            state_q   <= RESP;
            memReq_q  <= 1'b0;
            memWr_q   <= 1'b0;
            err_q     <= ~bus.i_Mem_Ready;
            ifReady_q <= (state_q == I_ACC);
            dReady_q  <= (state_q == D_ACC);
            if (state_q == I_ACC) begin
              ifData_q <= bus.i_Mem_Ready ? bus.i_Mem_RData : '0;
            end else if (!memWr_q) begin
              dRData_q <= bus.i_Mem_Ready ? bus.i_Mem_RData : '0;
            end
          end else begin
            timer_q <= timer_q + 8'd1;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.o_Mem_Req   = memReq_q;
  assign bus.o_Mem_Wr    = memWr_q;
  assign bus.o_Mem_Addr  = memAddr_q;
  assign bus.o_Mem_WData = memWData_q;
  assign bus.o_If_Ready  = ifReady_q;
  assign bus.o_If_Data   = ifData_q;
  assign bus.o_D_Ready   = dReady_q;
  assign bus.o_D_RData   = dRData_q;
  assign bus.o_Err       = err_q;
  assign bus.o_Stall     = (bus.i_If_Req & ~ifReady_q) | (bus.i_D_Req & ~dReady_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: arbitration/alternation, load/store data paths,
// latency, wait states, watchdog abort and mid-access reset, with a 4-cycle timeout.
module tb_mem_port_arbiter;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .i_Clk (clk),
    .i_Rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic ifReq, input logic [31:0] ifAddr, input logic dReq,
                               input logic dWr, input logic [31:0] dAddr, input logic [31:0] dWData);
    bus.i_If_Req  = ifReq;
    bus.i_If_Addr = ifAddr;
    bus.i_D_Req   = dReq;
    bus.i_D_Wr    = dWr;
    bus.i_D_Addr  = dAddr;
    bus.i_D_WData = dWData;
  endtask

  task automatic setMem(input logic ready, input logic [31:0] rdata);
    bus.i_Mem_Ready = ready;
    bus.i_Mem_RData = rdata;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    setMem(1'b0, 32'h0);
    step();
    step();

    // Reset state
    checkOutput("rst_mem_req", {31'b0, bus.o_Mem_Req}, 32'h0);
    checkOutput("rst_mem_addr", bus.o_Mem_Addr, 32'h0);
    checkOutput("rst_if_data", bus.o_If_Data, 32'h0);
    checkOutput("rst_d_rdata", bus.o_D_RData, 32'h0);
    checkOutput("rst_readies", {29'b0, bus.o_If_Ready, bus.o_D_Ready, bus.o_Err}, 32'h0);
    checkOutput("rst_stall", {31'b0, bus.o_Stall}, 32'h0);
    rst = 1'b0;
    step();

    // Both request from reset: data (store) first
    applyStimulus(1'b1, 32'h0, 1'b1, 1'b1, 32'h20, 32'h55);
    #1;
    checkOutput("both_stall", {31'b0, bus.o_Stall}, 32'h1);
    step();
    checkOutput("both_d_memreq", {31'b0, bus.o_Mem_Req}, 32'h1);
    checkOutput("both_d_memwr", {31'b0, bus.o_Mem_Wr}, 32'h1);
    checkOutput("both_d_addr", bus.o_Mem_Addr, 32'h20);
    checkOutput("both_d_wdata", bus.o_Mem_WData, 32'h55);
    setMem(1'b1, 32'h1111_1111);
    step();
    checkOutput("both_d_ready", {30'b0, bus.o_D_Ready, bus.o_If_Ready}, 32'h2);
    checkOutput("both_store_rdata", bus.o_D_RData, 32'h0);
    checkOutput("both_d_memreq_drop", {31'b0, bus.o_Mem_Req}, 32'h0);
    // Data immediately re-requests a load while fetch is still waiting: fetch must win
    setMem(1'b0, 32'h0);
    applyStimulus(1'b1, 32'h0, 1'b1, 1'b0, 32'h24, 32'h0);
    #1;
    checkOutput("both_stall_after_d", {31'b0, bus.o_Stall}, 32'h1);
    step();
    checkOutput("resp_to_idle_memreq", {31'b0, bus.o_Mem_Req}, 32'h0);
    step();
    checkOutput("alt_i_memreq", {31'b0, bus.o_Mem_Req}, 32'h1);
    checkOutput("alt_i_memwr", {31'b0, bus.o_Mem_Wr}, 32'h0);
    checkOutput("alt_i_addr", bus.o_Mem_Addr, 32'h0);
    setMem(1'b1, 32'h0000_0013);
    step();
    checkOutput("alt_i_ready", {30'b0, bus.o_D_Ready, bus.o_If_Ready}, 32'h1);
    checkOutput("alt_i_data", bus.o_If_Data, 32'h13);
    setMem(1'b0, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h24, 32'h0);
    step();
    step();
    checkOutput("alt_d_addr", bus.o_Mem_Addr, 32'h24);
    checkOutput("alt_d_memwr", {31'b0, bus.o_Mem_Wr}, 32'h0);
    setMem(1'b1, 32'hCAFE_F00D);
    step();
    checkOutput("alt_d_ready", {31'b0, bus.o_D_Ready}, 32'h1);
    checkOutput("alt_d_rdata", bus.o_D_RData, 32'hCAFE_F00D);
    setMem(1'b0, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();

    // Load latency: request at N, ready at N+1, pulse at N+2
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h10, 32'h0);
    step();
    checkOutput("ld_memreq", {31'b0, bus.o_Mem_Req}, 32'h1);
    checkOutput("ld_addr", bus.o_Mem_Addr, 32'h10);
    checkOutput("ld_no_early_ready", {31'b0, bus.o_D_Ready}, 32'h0);
    setMem(1'b1, 32'hDEAD_BEEF);
    step();
    checkOutput("ld_ready", {31'b0, bus.o_D_Ready}, 32'h1);
    checkOutput("ld_rdata", bus.o_D_RData, 32'hDEAD_BEEF);
    checkOutput("ld_stall_clear", {31'b0, bus.o_Stall}, 32'h0);
    setMem(1'b0, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    checkOutput("ld_pulse_one_cycle", {31'b0, bus.o_D_Ready}, 32'h0);

    // Store leaves the previous load data untouched
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h30, 32'h77);
    step();
    checkOutput("st_memwr", {31'b0, bus.o_Mem_Wr}, 32'h1);
    checkOutput("st_wdata", bus.o_Mem_WData, 32'h77);
    setMem(1'b1, 32'h1234_5678);
    step();
    checkOutput("st_ready", {31'b0, bus.o_D_Ready}, 32'h1);
    checkOutput("st_keeps_rdata", bus.o_D_RData, 32'hDEAD_BEEF);
    setMem(1'b0, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();

    // Watchdog: memory never answers a load
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0);
    step();
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("to_memreq_%0d", i), {31'b0, bus.o_Mem_Req}, 32'h1);
      checkOutput($sformatf("to_no_ready_%0d", i), {31'b0, bus.o_D_Ready}, 32'h0);
      step();
    end
    checkOutput("to_ready_err", {30'b0, bus.o_D_Ready, bus.o_Err}, 32'h3);
    checkOutput("to_rdata_zero", bus.o_D_RData, 32'h0);
    checkOutput("to_memreq_drop", {31'b0, bus.o_Mem_Req}, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    checkOutput("to_err_one_cycle", {31'b0, bus.o_Err}, 32'h0);

    // Fetch with three wait states
    applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("ws_addr_%0d", i), bus.o_Mem_Addr, 32'h100);
      checkOutput($sformatf("ws_memreq_%0d", i), {31'b0, bus.o_Mem_Req}, 32'h1);
      checkOutput($sformatf("ws_stall_%0d", i), {31'b0, bus.o_Stall}, 32'h1);
      step();
    end
    checkOutput("ws_addr_3", bus.o_Mem_Addr, 32'h100);
    checkOutput("ws_stall_3", {31'b0, bus.o_Stall}, 32'h1);
    setMem(1'b1, 32'hABCD_0001);
    step();
    checkOutput("ws_ready", {31'b0, bus.o_If_Ready}, 32'h1);
    checkOutput("ws_no_err", {31'b0, bus.o_Err}, 32'h0);
    checkOutput("ws_data", bus.o_If_Data, 32'hABCD_0001);
    checkOutput("ws_stall_clear", {31'b0, bus.o_Stall}, 32'h0);
    setMem(1'b0, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();

    // Reset during a fetch access
    applyStimulus(1'b1, 32'h200, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    checkOutput("rstacc_memreq", {31'b0, bus.o_Mem_Req}, 32'h1);
    checkOutput("rstacc_addr", bus.o_Mem_Addr, 32'h200);
    rst = 1'b1;
    step();
    checkOutput("rstacc_memreq_drop", {31'b0, bus.o_Mem_Req}, 32'h0);
    checkOutput("rstacc_no_ready", {31'b0, bus.o_If_Ready}, 32'h0);
    rst = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    checkOutput("rstacc_after_flags", {29'b0, bus.o_If_Ready, bus.o_Err, bus.o_Mem_Req}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
